// File: rtl/power_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : power_cmd_arbiter
// Brief   : S0 power/reset sequencer; arbitrates on/off/reset commands from
//           button, AST, LPC and IIC sources and drives the host-up flag.
// Rev     : 1.0  initial release
// ============================================================================
module power_cmd_arbiter #(
    parameter int PCIE_RST_CYC = 40,
    parameter int STEP_CYC     = 4,
    parameter int PG_TIMEOUT   = 1024
) (
    input  logic       clk,
    input  logic       i_rst_n,
    input  logic       i_btn_on,
    input  logic       i_btn_off,
    input  logic       i_btn_rst,
    input  logic       i_ast_on,
    input  logic       i_ast_off,
    input  logic       i_ast_rst,
    input  logic       i_lpc_vld,
    input  logic [7:0] i_lpc_cmd,
    input  logic       i_iic_vld,
    input  logic [7:0] i_iic_cmd,
    input  logic       i_pwr_good,
    output logic       o_pwr_en,
    output logic       o_PCIEReset0_n,
    output logic       o_ipmi_perst_n,
    output logic       o_S0_CPU_DCOK,
    output logic       o_S0_CPUReset_n,
    output logic       o_CPLD_INT,
    output logic       o_busy,
    output logic [3:0] o_ack,
    output logic       o_drop,
    output logic       o_fault
);

    localparam int c_CNT_MAX = (PCIE_RST_CYC > PG_TIMEOUT) ? PCIE_RST_CYC : PG_TIMEOUT;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_PCIE_LAST = c_CNT_W'(PCIE_RST_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_STEP_LAST = c_CNT_W'(STEP_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_PG_LAST   = c_CNT_W'(PG_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    // Command classes, listed in descending priority
    localparam logic [1:0] c_CLS_OFF  = 2'd0;
    localparam logic [1:0] c_CLS_SRST = 2'd1;
    localparam logic [1:0] c_CLS_MRST = 2'd2;
    localparam logic [1:0] c_CLS_ON   = 2'd3;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_PWR_UP    = 3'd1,
        ST_RST_HOLD  = 3'd2,
        ST_DCOK_WAIT = 3'd3,
        ST_CRST_WAIT = 3'd4,
        ST_ON        = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;

    logic r_pwr_en, r_pcie, r_dcok, r_cpurst, r_int, r_fault, r_pending_off;
    logic w_pwr_en_nxt, w_pcie_nxt, w_dcok_nxt, w_cpurst_nxt, w_int_nxt;
    logic w_fault_nxt, w_pending_nxt;

    logic [3:0]      w_lpc_cls;
    logic [3:0]      w_iic_cls;
    logic [3:0][3:0] w_req;       // [class][source], source 0=btn 1=ast 2=lpc 3=iic
    logic [3:0][3:0] w_granted;
    logic [3:0]      w_allow;
    logic            w_grant_vld;
    logic [3:0]      w_grant_src;
    logic [1:0]      w_grant_cls;
    logic            w_up;
    logic            w_emerg;

    function automatic logic [3:0] decode_cmd(input logic vld, input logic [7:0] code);
        logic [3:0] cls;
        cls = 4'b0000;
        if (vld) begin
            case (code)
                8'hF0:   cls = 4'b0001;
                8'hC3:   cls = 4'b0010;
                8'hEE:   cls = 4'b0100;
                8'h0F:   cls = 4'b1000;
                default: cls = 4'b0000;
            endcase
        end
        return cls;
    endfunction

    always_comb begin
        w_lpc_cls = decode_cmd(i_lpc_vld, i_lpc_cmd);
        w_iic_cls = decode_cmd(i_iic_vld, i_iic_cmd);
        w_req     = '0;
        if (i_rst_n) begin
            w_req[c_CLS_OFF]  = {w_iic_cls[0], w_lpc_cls[0], i_ast_off, i_btn_off};
            w_req[c_CLS_SRST] = {w_iic_cls[1], w_lpc_cls[1], i_ast_rst, i_btn_rst};
            w_req[c_CLS_MRST] = {w_iic_cls[2], w_lpc_cls[2], 1'b0, 1'b0};
            w_req[c_CLS_ON]   = {w_iic_cls[3], w_lpc_cls[3], i_ast_on, i_btn_on};
        end
    end

    // Rails are expected good from reset-hold onward; losing them there is fatal
    assign w_up    = (r_state == ST_RST_HOLD) || (r_state == ST_DCOK_WAIT) ||
                     (r_state == ST_CRST_WAIT) || (r_state == ST_ON);
    assign w_emerg = w_up && !i_pwr_good;

    always_comb begin
        w_allow = 4'b0000;
        case (r_state)
            ST_OFF:
                w_allow = 4'b1000;
            ST_PWR_UP, ST_RST_HOLD, ST_DCOK_WAIT, ST_CRST_WAIT:
                w_allow = w_emerg ? 4'b0000 : 4'b0001;
            ST_ON:
                w_allow = (w_emerg || r_pending_off) ? 4'b0000 : 4'b0111;
            default:
                w_allow = 4'b0000;
        endcase
    end

    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_src = 4'b0000;
        w_grant_cls = 2'd0;
        for (int c = 0; c < 4; c++) begin
            for (int s = 0; s < 4; s++) begin
                if (!w_grant_vld && w_allow[c] && w_req[c][s]) begin
                    w_grant_vld    = 1'b1;
                    w_grant_src[s] = 1'b1;
                    w_grant_cls    = 2'(c);
                end
            end
        end
    end

    always_comb begin
        w_granted = '0;
        if (w_grant_vld) begin
            w_granted[w_grant_cls] = w_grant_src;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + c_CNT_ONE;
        w_pwr_en_nxt  = r_pwr_en;
        w_pcie_nxt    = r_pcie;
        w_dcok_nxt    = r_dcok;
        w_cpurst_nxt  = r_cpurst;
        w_int_nxt     = r_int;
        w_fault_nxt   = r_fault;
        w_pending_nxt = r_pending_off;

        case (r_state)
            ST_OFF: begin
                w_cnt_nxt = '0;
                if (w_grant_vld) begin
                    w_state_nxt  = ST_PWR_UP;
                    w_pwr_en_nxt = 1'b1;
                    w_fault_nxt  = 1'b0;
                end
            end
            ST_PWR_UP: begin
                if (w_grant_vld) begin
                    w_pending_nxt = 1'b1;
                end
                if (i_pwr_good) begin
                    w_state_nxt = ST_RST_HOLD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_PG_LAST) begin
                    w_state_nxt   = ST_OFF;
                    w_cnt_nxt     = '0;
                    w_pwr_en_nxt  = 1'b0;
                    w_fault_nxt   = 1'b1;
                    w_pending_nxt = 1'b0;
                end
            end
            ST_RST_HOLD: begin
                if (w_grant_vld) begin
                    w_pending_nxt = 1'b1;
                end
                if (r_cnt == c_PCIE_LAST) begin
                    w_state_nxt = ST_DCOK_WAIT;
                    w_cnt_nxt   = '0;
                    w_pcie_nxt  = 1'b1;
                end
            end
            ST_DCOK_WAIT: begin
                if (w_grant_vld) begin
                    w_pending_nxt = 1'b1;
                end
                if (r_cnt == c_STEP_LAST) begin
                    w_state_nxt = ST_CRST_WAIT;
                    w_cnt_nxt   = '0;
                    w_dcok_nxt  = 1'b1;
                end
            end
            ST_CRST_WAIT: begin
                if (w_grant_vld) begin
                    w_pending_nxt = 1'b1;
                end
                if (r_cnt == c_STEP_LAST) begin
                    w_state_nxt  = ST_ON;
                    w_cnt_nxt    = '0;
                    w_cpurst_nxt = 1'b1;
                    // A queued off keeps the host-up flag from ever asserting
                    w_int_nxt    = !w_pending_nxt;
                end
            end
            ST_ON: begin
                w_cnt_nxt = '0;
                if (r_pending_off || (w_grant_vld && (w_grant_cls == c_CLS_OFF))) begin
                    w_state_nxt   = ST_OFF;
                    w_pwr_en_nxt  = 1'b0;
                    w_pcie_nxt    = 1'b0;
                    w_dcok_nxt    = 1'b0;
                    w_cpurst_nxt  = 1'b0;
                    w_int_nxt     = 1'b0;
                    w_pending_nxt = 1'b0;
                end else if (w_grant_vld && (w_grant_cls == c_CLS_SRST)) begin
                    w_state_nxt  = ST_RST_HOLD;
                    w_pcie_nxt   = 1'b0;
                    w_dcok_nxt   = 1'b0;
                    w_cpurst_nxt = 1'b0;
                    w_int_nxt    = 1'b0;
                end else if (w_grant_vld && (w_grant_cls == c_CLS_MRST)) begin
                    w_state_nxt  = ST_DCOK_WAIT;
                    w_dcok_nxt   = 1'b0;
                    w_cpurst_nxt = 1'b0;
                    w_int_nxt    = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_OFF;
                w_cnt_nxt   = '0;
            end
        endcase

        if (w_emerg) begin
            w_state_nxt   = ST_OFF;
            w_cnt_nxt     = '0;
            w_pwr_en_nxt  = 1'b0;
            w_pcie_nxt    = 1'b0;
            w_dcok_nxt    = 1'b0;
            w_cpurst_nxt  = 1'b0;
            w_int_nxt     = 1'b0;
            w_fault_nxt   = 1'b1;
            w_pending_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_state       <= ST_OFF;
            r_cnt         <= '0;
            r_pwr_en      <= 1'b0;
            r_pcie        <= 1'b0;
            r_dcok        <= 1'b0;
            r_cpurst      <= 1'b0;
            r_int         <= 1'b0;
            r_fault       <= 1'b0;
            r_pending_off <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_pwr_en      <= w_pwr_en_nxt;
            r_pcie        <= w_pcie_nxt;
            r_dcok        <= w_dcok_nxt;
            r_cpurst      <= w_cpurst_nxt;
            r_int         <= w_int_nxt;
            r_fault       <= w_fault_nxt;
            r_pending_off <= w_pending_nxt;
        end
    end

    assign o_pwr_en        = r_pwr_en;
    assign o_PCIEReset0_n  = r_pcie;
    assign o_ipmi_perst_n  = r_pcie;
    assign o_S0_CPU_DCOK   = r_dcok;
    assign o_S0_CPUReset_n = r_cpurst;
    // Host-up drops in the very cycle a leave-ON command is accepted
    assign o_CPLD_INT      = r_int && !((r_state == ST_ON) && w_grant_vld);
    assign o_busy          = (r_state != ST_OFF) && (r_state != ST_ON);
    assign o_ack           = w_grant_vld ? w_grant_src : 4'b0000;
    assign o_drop          = |(w_req & ~w_granted);
    assign o_fault         = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_power_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_power_cmd_arbiter
// Brief   : Scoreboard bench for power_cmd_arbiter; timeline reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_power_cmd_arbiter;

    localparam int PCIE_RST_CYC = 40;
    localparam int STEP_CYC     = 4;
    localparam int PG_TIMEOUT   = 1024;
    localparam int c_INF        = 32'h3fff_ffff;

    typedef struct packed {
        logic       pwr_en;
        logic       pcie;
        logic       perst;
        logic       dcok;
        logic       cpurst;
        logic       cint;
        logic       busy;
        logic [3:0] ack;
        logic       drop;
        logic       fault;
    } out_t;

    logic       clk;
    logic       i_rst_n;
    logic       i_btn_on, i_btn_off, i_btn_rst;
    logic       i_ast_on, i_ast_off, i_ast_rst;
    logic       i_lpc_vld;
    logic [7:0] i_lpc_cmd;
    logic       i_iic_vld;
    logic [7:0] i_iic_cmd;
    logic       i_pwr_good;
    logic       o_pwr_en, o_PCIEReset0_n, o_ipmi_perst_n, o_S0_CPU_DCOK;
    logic       o_S0_CPUReset_n, o_CPLD_INT, o_busy, o_drop, o_fault;
    logic [3:0] o_ack;

    power_cmd_arbiter #(
        .PCIE_RST_CYC (PCIE_RST_CYC),
        .STEP_CYC     (STEP_CYC),
        .PG_TIMEOUT   (PG_TIMEOUT)
    ) u_dut (
        .clk             (clk),
        .i_rst_n         (i_rst_n),
        .i_btn_on        (i_btn_on),
        .i_btn_off       (i_btn_off),
        .i_btn_rst       (i_btn_rst),
        .i_ast_on        (i_ast_on),
        .i_ast_off       (i_ast_off),
        .i_ast_rst       (i_ast_rst),
        .i_lpc_vld       (i_lpc_vld),
        .i_lpc_cmd       (i_lpc_cmd),
        .i_iic_vld       (i_iic_vld),
        .i_iic_cmd       (i_iic_cmd),
        .i_pwr_good      (i_pwr_good),
        .o_pwr_en        (o_pwr_en),
        .o_PCIEReset0_n  (o_PCIEReset0_n),
        .o_ipmi_perst_n  (o_ipmi_perst_n),
        .o_S0_CPU_DCOK   (o_S0_CPU_DCOK),
        .o_S0_CPUReset_n (o_S0_CPUReset_n),
        .o_CPLD_INT      (o_CPLD_INT),
        .o_busy          (o_busy),
        .o_ack           (o_ack),
        .o_drop          (o_drop),
        .o_fault         (o_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    out_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   n        = 0;
    int   mon_cyc  = 0;
    out_t mon_exp, mon_got;

    // Reference model: a power timeline of absolute cycle numbers at which each
    // reset/ok signal is released, plus a few flags.
    bit m_powered, m_wait_pg, m_fault, m_pending;
    int m_pg_last, t_pcie, t_dcok, t_crst;

    function automatic int code_cls(input logic [7:0] code);
        case (code)
            8'hF0:   return 0;
            8'hC3:   return 1;
            8'hEE:   return 2;
            8'h0F:   return 3;
            default: return -1;
        endcase
    endfunction

    task automatic power_down();
        m_powered = 1'b0;
        m_wait_pg = 1'b0;
        m_pending = 1'b0;
        t_pcie    = c_INF;
        t_dcok    = c_INF;
        t_crst    = c_INF;
    endtask

    task automatic model_reset();
        power_down();
        m_fault = 1'b0;
    endtask

    task automatic start_hold(input int entry);
        t_pcie = entry + PCIE_RST_CYC;
        t_dcok = t_pcie + STEP_CYC;
        t_crst = t_dcok + STEP_CYC;
    endtask

    task automatic model_cycle();
        bit [3:0] req [4];
        bit [3:0] allow;
        bit       up, in_seq, on_s, busy_s, emerg, lose;
        int       g_c, g_s, lc, ic;
        out_t     e;

        for (int c = 0; c < 4; c++) req[c] = 4'b0000;
        if (i_rst_n) begin
            req[0][0] = i_btn_off; req[1][0] = i_btn_rst; req[3][0] = i_btn_on;
            req[0][1] = i_ast_off; req[1][1] = i_ast_rst; req[3][1] = i_ast_on;
            lc = code_cls(i_lpc_cmd);
            ic = code_cls(i_iic_cmd);
            if (i_lpc_vld && lc >= 0) req[lc][2] = 1'b1;
            if (i_iic_vld && ic >= 0) req[ic][3] = 1'b1;
        end

        up     = m_powered && !m_wait_pg;
        in_seq = up && (n < t_crst);
        on_s   = up && (n >= t_crst);
        busy_s = (m_powered && m_wait_pg) || in_seq;
        emerg  = up && !i_pwr_good;
        if (!m_powered)  allow = 4'b1000;
        else if (busy_s) allow = emerg ? 4'b0000 : 4'b0001;
        else             allow = (emerg || m_pending) ? 4'b0000 : 4'b0111;

        // rank = class*4 + source; lowest allowed rank wins
        g_c = -1;
        g_s = -1;
        for (int rank = 15; rank >= 0; rank--) begin
            if (allow[rank / 4] && req[rank / 4][rank % 4]) begin
                g_c = rank / 4;
                g_s = rank % 4;
            end
        end
        lose = 1'b0;
        for (int c = 0; c < 4; c++)
            for (int s = 0; s < 4; s++)
                if (req[c][s] && !(c == g_c && s == g_s)) lose = 1'b1;

        e.pwr_en = m_powered;
        e.pcie   = up && (n >= t_pcie);
        e.perst  = e.pcie;
        e.dcok   = up && (n >= t_dcok);
        e.cpurst = on_s;
        e.cint   = on_s && !m_pending && (g_c < 0);
        e.busy   = busy_s;
        e.ack    = (g_s >= 0) ? 4'(1 << g_s) : 4'b0000;
        e.drop   = lose;
        e.fault  = m_fault;
        exp_q.push_back(e);

        if (!i_rst_n) begin
            model_reset();
        end else if (emerg) begin
            power_down();
            m_fault = 1'b1;
        end else if (!m_powered) begin
            if (g_c == 3) begin
                m_powered = 1'b1;
                m_wait_pg = 1'b1;
                m_fault   = 1'b0;
                m_pg_last = n + PG_TIMEOUT;
            end
        end else if (busy_s) begin
            if (g_c == 0) m_pending = 1'b1;
            if (m_wait_pg) begin
                if (i_pwr_good) begin
                    m_wait_pg = 1'b0;
                    start_hold(n + 1);
                end else if (n == m_pg_last) begin
                    power_down();
                    m_fault = 1'b1;
                end
            end
        end else begin
            if (m_pending || g_c == 0) begin
                power_down();
            end else if (g_c == 1) begin
                start_hold(n + 1);
            end else if (g_c == 2) begin
                t_dcok = n + 1 + STEP_CYC;
                t_crst = t_dcok + STEP_CYC;
            end
        end
    endtask

    task automatic clear_pulses();
        i_btn_on  = 1'b0; i_btn_off = 1'b0; i_btn_rst = 1'b0;
        i_ast_on  = 1'b0; i_ast_off = 1'b0; i_ast_rst = 1'b0;
        i_lpc_vld = 1'b0; i_lpc_cmd = 8'h00;
        i_iic_vld = 1'b0; i_iic_cmd = 8'h00;
    endtask

    task automatic run_cycle();
        model_cycle();
        @(posedge clk);
        #1;
        clear_pulses();
        n++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) run_cycle();
    endtask

    function automatic logic [7:0] pick_cmd();
        case ($urandom_range(0, 4))
            0:       return 8'h0F;
            1:       return 8'hF0;
            2:       return 8'hC3;
            3:       return 8'hEE;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_got = {o_pwr_en, o_PCIEReset0_n, o_ipmi_perst_n, o_S0_CPU_DCOK,
                       o_S0_CPUReset_n, o_CPLD_INT, o_busy, o_ack, o_drop, o_fault};
            checks++;
            if (mon_got !== mon_exp) begin
                failures++;
                $display("FAIL outputs cyc=%0d {pwr_en,pcie,perst,dcok,cpurst,int,busy,ack,drop,fault} got=%b required=%b",
                         mon_cyc, mon_got, mon_exp);
            end
            mon_cyc++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", n);
        $fatal(1, "watchdog");
    end

    bit dead;
    bit prev_powered;

    initial begin
        clear_pulses();
        i_rst_n    = 1'b0;
        i_pwr_good = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        idle(3);
        i_rst_n = 1'b1;
        idle(3);

        // button power-on, rails good five cycles later, full release sequence
        i_btn_on = 1'b1; run_cycle();
        idle(4);
        i_pwr_good = 1'b1;
        idle(60);
        i_btn_on = 1'b1; run_cycle();
        idle(2);

        // soft reset from LPC
        i_lpc_vld = 1'b1; i_lpc_cmd = 8'hC3; run_cycle();
        idle(55);

        // MT reset from IIC
        i_iic_vld = 1'b1; i_iic_cmd = 8'hEE; run_cycle();
        idle(15);

        // reset and off in the same cycle: off wins
        i_ast_rst = 1'b1; i_iic_vld = 1'b1; i_iic_cmd = 8'hF0; run_cycle();
        i_pwr_good = 1'b0;
        idle(5);

        // contended on, junk IIC code, off dropped while OFF
        i_btn_off = 1'b1; i_ast_on = 1'b1;
        i_lpc_vld = 1'b1; i_lpc_cmd = 8'h0F;
        i_iic_vld = 1'b1; i_iic_cmd = 8'h55;
        run_cycle();
        idle(3);
        i_pwr_good = 1'b1;
        idle(10);
        i_btn_off = 1'b1; run_cycle();
        idle(60);
        i_pwr_good = 1'b0;
        idle(3);

        // rails collapse while ON
        i_iic_vld = 1'b1; i_iic_cmd = 8'h0F; run_cycle();
        idle(2);
        i_pwr_good = 1'b1;
        idle(60);
        i_pwr_good = 1'b0;
        idle(4);

        // power-good never arrives
        i_ast_on = 1'b1; run_cycle();
        idle(PG_TIMEOUT + 5);

        // reset asserted during DCOK_WAIT
        i_btn_on = 1'b1; run_cycle();
        idle(2);
        i_pwr_good = 1'b1; run_cycle();
        idle(42);
        i_rst_n = 1'b0; run_cycle();
        i_rst_n = 1'b1;
        i_pwr_good = 1'b0;
        idle(3);

        // randomized traffic with a rail supply that mostly behaves
        dead = 1'b0;
        prev_powered = m_powered;
        for (int k = 0; k < 6000; k++) begin
            if (m_powered && !prev_powered) dead = ($urandom_range(0, 9) == 0);
            prev_powered = m_powered;
            if (!m_powered) begin
                i_pwr_good = 1'b0;
            end else if (!i_pwr_good) begin
                if (!dead && $urandom_range(0, 7) == 0) i_pwr_good = 1'b1;
            end else if ($urandom_range(0, 1999) == 0) begin
                i_pwr_good = 1'b0;
            end
            i_rst_n   = ($urandom_range(0, 1999) != 0);
            i_btn_on  = ($urandom_range(0, 119) == 0);
            i_btn_off = ($urandom_range(0, 119) == 0);
            i_btn_rst = ($urandom_range(0, 119) == 0);
            i_ast_on  = ($urandom_range(0, 119) == 0);
            i_ast_off = ($urandom_range(0, 119) == 0);
            i_ast_rst = ($urandom_range(0, 119) == 0);
            if ($urandom_range(0, 79) == 0) begin
                i_lpc_vld = 1'b1;
                i_lpc_cmd = pick_cmd();
            end
            if ($urandom_range(0, 79) == 0) begin
                i_iic_vld = 1'b1;
                i_iic_cmd = pick_cmd();
            end
            run_cycle();
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
